pipe_memory: RTL and testbench

PIPE_MEMORY -- requirements
Module: pipe_memory

---
 rtl/pipe_memory_pkg.sv | 15 +
 rtl/pipe_memwb.sv | 40 ++++
 rtl/pipe_memory.sv | 148 ++++++++++++++
 tb/tb_pipe_memory.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_memory_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the stage FSM encoding, the busy-counter width and the default
// memory timeout used by pipe_memory.
package pipe_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipe_memwb.sv
// MEM/WB pipeline register bank; loads on en, 1-cycle latency.
// bubble has priority over en: it clears q_regwrite and q_halt (q_halt is
// kept only when halt_keep=1), leaving the data fields untouched.
// Ports: clk, rst (async high), en, bubble, halt_keep, d_* in, q_* out.
module pipe_memwb
  import pipe_memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic        halt_keep,
  input  logic [15:0] d_writedata,
  input  logic [2:0]  d_writereg,
  input  logic        d_regwrite,
  input  logic        d_halt,
  output logic [15:0] q_writedata,
  output logic [2:0]  q_writereg,
  output logic        q_regwrite,
  output logic        q_halt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_writedata <= 16'h0000;
      q_writereg  <= 3'd0;
      q_regwrite  <= 1'b0;
      q_halt      <= 1'b0;
    end else if (bubble) begin
      q_regwrite <= 1'b0;
      q_halt     <= halt_keep & q_halt;
    end else if (en) begin
      q_writedata <= d_writedata;
      q_writereg  <= d_writereg;
      q_regwrite  <= d_regwrite;
      q_halt      <= d_halt;
    end
  end

endmodule

// File: rtl/pipe_memory.sv
// MEM stage: issues one-cycle data-memory request strobes, stalls the
// upstream pipeline until mem_done (or a TIMEOUT-cycle watchdog expiry,
// which sets sticky mem_err and returns 0 data), then loads MEM/WB.
// Ports: clk, rst (async high), d_* EX/MEM fields, mem_* memory side,
// stall to upstream, q_* MEM/WB outputs, mem_err.
module pipe_memory
  import pipe_memory_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_PC_incr,
  input  logic [15:0] d_ALU_out,
  input  logic [15:0] d_mem_write_data,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic        d_memtoreg,
  input  logic        d_regwrite,
  input  logic        d_jumpl,
  input  logic        d_halt,
  input  logic [2:0]  d_writereg,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall,
  output logic [15:0] q_writedata,
  output logic [2:0]  q_writereg,
  output logic        q_regwrite,
  output logic        q_halt,
  output logic        mem_err
);

  // The watchdog fires on the TIMEOUT-th BUSY cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rd_req_c, wr_req_c, stall_c;
  logic             cnt_clr, cnt_inc, err_set, timeout_hit;
  logic             capture, bubble, halt_keep;
  logic [15:0]      wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc && cnt != '1)
        cnt <= cnt + 1'b1;
      if (err_set)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_req_c    = 1'b0;
    wr_req_c    = 1'b0;
    stall_c     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    err_set     = 1'b0;
    timeout_hit = 1'b0;
    capture     = 1'b0;
    bubble      = 1'b0;
    halt_keep   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_mem_read || d_mem_write) begin
          // Read wins when both are set; the write is dropped.
          rd_req_c  = d_mem_read;
          wr_req_c  = d_mem_write & ~d_mem_read;
          stall_c   = 1'b1;
          bubble    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_BUSY;
        end else begin
          capture = 1'b1;
          if (d_halt)
            state_nxt = ST_HALTED;
        end
      end
      ST_BUSY: begin
        if (mem_done) begin
          capture   = 1'b1;
          state_nxt = d_halt ? ST_HALTED : ST_IDLE;
        end else if (cnt >= TO_LIM) begin
          timeout_hit = 1'b1;
          err_set     = 1'b1;
          capture     = 1'b1;
          state_nxt   = d_halt ? ST_HALTED : ST_IDLE;
        end else begin
          stall_c = 1'b1;
          bubble  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      ST_HALTED: begin
        bubble    = 1'b1;
        halt_keep = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Upstream holds EX/MEM while stalled, so these stay stable through BUSY.
  assign mem_addr  = d_ALU_out;
  assign mem_wdata = d_mem_write_data;

  // Strobes and stall are combinational; force them low while in reset.
  assign mem_rd_req = rd_req_c & ~rst;
  assign mem_wr_req = wr_req_c & ~rst;
  assign stall      = stall_c & ~rst;

  always_comb begin
    if (d_jumpl)
      wb_data = d_PC_incr;
    else if (d_memtoreg)
      wb_data = timeout_hit ? 16'h0000 : mem_rdata;
    else
      wb_data = d_ALU_out;
  end

  pipe_memwb u_memwb (
    .clk         (clk),
    .rst         (rst),
    .en          (capture),
    .bubble      (bubble),
    .halt_keep   (halt_keep),
    .d_writedata (wb_data),
    .d_writereg  (d_writereg),
    .d_regwrite  (d_regwrite),
    .d_halt      (d_halt),
    .q_writedata (q_writedata),
    .q_writereg  (q_writereg),
    .q_regwrite  (q_regwrite),
    .q_halt      (q_halt)
  );

endmodule

// File: tb/tb_pipe_memory.sv
// Bench for pipe_memory with TIMEOUT=4: directed scenarios plus random
// instructions checked against an instruction-level model that predicts
// stall length, writeback value and error state from done delay alone.
module tb_pipe_memory;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_PC_incr, d_ALU_out, d_mem_write_data;
  logic        d_mem_read, d_mem_write, d_memtoreg, d_regwrite, d_jumpl, d_halt;
  logic [2:0]  d_writereg;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_req, mem_wr_req, mem_done, stall;
  logic [15:0] q_writedata;
  logic [2:0]  q_writereg;
  logic        q_regwrite, q_halt, mem_err;

  int errors = 0;
  int checks = 0;

  // Instruction-level model state.
  logic [15:0] exp_wd;
  logic [2:0]  exp_wr;
  logic        exp_rw, exp_halt, exp_err, halted;

  always #5 clk = ~clk;

  pipe_memory #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .d_PC_incr(d_PC_incr), .d_ALU_out(d_ALU_out), .d_mem_write_data(d_mem_write_data),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_memtoreg(d_memtoreg),
    .d_regwrite(d_regwrite), .d_jumpl(d_jumpl), .d_halt(d_halt), .d_writereg(d_writereg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall(stall),
    .q_writedata(q_writedata), .q_writereg(q_writereg), .q_regwrite(q_regwrite),
    .q_halt(q_halt), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, ".q_writedata"}, q_writedata, exp_wd);
    check({tag, ".q_writereg"}, {13'd0, q_writereg}, {13'd0, exp_wr});
    check({tag, ".q_regwrite"}, {15'd0, q_regwrite}, {15'd0, exp_rw});
    check({tag, ".q_halt"}, {15'd0, q_halt}, {15'd0, exp_halt});
    check({tag, ".mem_err"}, {15'd0, mem_err}, {15'd0, exp_err});
  endtask

  // One instruction through MEM. k = number of BUSY cycles that pass
  // before mem_done is raised (k >= TMO means the memory never answers);
  // for non-memory instructions k != 0 injects a stray mem_done pulse.
  task automatic run_instr(input string tag,
                           input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                           input logic rd, input logic wr, input logic m2r, input logic rw,
                           input logic jl, input logic hl, input logic [2:0] wreg,
                           input int k, input logic [15:0] rdata);
    logic [15:0] res;
    int          busy_n;
    bit          tmo;
    d_PC_incr = pc; d_ALU_out = alu; d_mem_write_data = wd;
    d_mem_read = rd; d_mem_write = wr; d_memtoreg = m2r; d_regwrite = rw;
    d_jumpl = jl; d_halt = hl; d_writereg = wreg;
    mem_done = 1'b0;
    if (halted) begin
      @(negedge clk);
      check({tag, ".halt_stall"}, {15'd0, stall}, 16'd0);
      check({tag, ".halt_req"}, {14'd0, mem_rd_req, mem_wr_req}, 16'd0);
      @(posedge clk); #1;
      check_q(tag);
      return;
    end
    if (!(rd || wr)) begin
      mem_done  = (k != 0);
      mem_rdata = rdata;
      @(negedge clk);
      check({tag, ".stall"}, {15'd0, stall}, 16'd0);
      check({tag, ".req"}, {14'd0, mem_rd_req, mem_wr_req}, 16'd0);
      @(posedge clk); #1;
      mem_done = 1'b0;
      res = jl ? pc : alu;
    end else begin
      @(negedge clk);
      check({tag, ".rd_req"}, {15'd0, mem_rd_req}, {15'd0, rd});
      check({tag, ".wr_req"}, {15'd0, mem_wr_req}, {15'd0, wr & ~rd});
      check({tag, ".stall0"}, {15'd0, stall}, 16'd1);
      check({tag, ".addr"}, mem_addr, alu);
      check({tag, ".wdata"}, mem_wdata, wd);
      @(posedge clk); #1;
      check({tag, ".bubble_rw"}, {15'd0, q_regwrite}, 16'd0);
      check({tag, ".bubble_wd"}, q_writedata, exp_wd);
      tmo    = (k >= TMO);
      busy_n = tmo ? TMO : k + 1;
      for (int i = 0; i < busy_n; i++) begin
        if (i == k) begin
          mem_done  = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_rdata = 16'($urandom);
        end
        @(negedge clk);
        check({tag, ".busy_stall"}, {15'd0, stall}, (i == busy_n - 1) ? 16'd0 : 16'd1);
        check({tag, ".busy_req"}, {14'd0, mem_rd_req, mem_wr_req}, 16'd0);
        check({tag, ".busy_addr"}, mem_addr, alu);
        @(posedge clk); #1;
        mem_done = 1'b0;
        if (i != busy_n - 1)
          check({tag, ".busy_rw"}, {15'd0, q_regwrite}, 16'd0);
      end
      res = jl ? pc : (m2r ? (tmo ? 16'h0000 : rdata) : alu);
      if (tmo) exp_err = 1'b1;
    end
    exp_wd = res; exp_wr = wreg; exp_rw = rw; exp_halt = hl;
    if (hl) halted = 1'b1;
    check_q(tag);
  endtask

  task automatic model_reset();
    exp_wd = 16'h0000; exp_wr = 3'd0; exp_rw = 1'b0; exp_halt = 1'b0;
    exp_err = 1'b0; halted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, k;
    logic [15:0] a, w, p, r;
    rst = 1'b1;
    d_PC_incr = '0; d_ALU_out = '0; d_mem_write_data = '0;
    d_mem_read = 0; d_mem_write = 0; d_memtoreg = 0; d_regwrite = 0;
    d_jumpl = 0; d_halt = 0; d_writereg = '0;
    mem_rdata = '0; mem_done = 0;
    model_reset();
    #12;
    check("reset.stall", {15'd0, stall}, 16'd0);
    check("reset.req", {14'd0, mem_rd_req, mem_wr_req}, 16'd0);
    check_q("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU result passes straight through with one-cycle latency.
    run_instr("alu", 16'h0000, 16'h1234, 16'h0000, 0, 0, 0, 1, 0, 0, 3'd3, 0, 16'h0);
    // Load answered after 3 wait cycles: stall high for 4 cycles.
    run_instr("load", 16'h0000, 16'h0040, 16'h0000, 1, 0, 1, 1, 0, 0, 3'd5, 3, 16'hBEEF);
    // Store answered immediately.
    run_instr("store", 16'h0000, 16'h0010, 16'h00AA, 0, 1, 0, 0, 0, 0, 3'd1, 0, 16'h5555);
    // Read and write together: read wins.
    run_instr("rdwr", 16'h0000, 16'h0022, 16'h0033, 1, 1, 1, 1, 0, 0, 3'd2, 1, 16'h4321);
    // Memory never answers: watchdog after TMO BUSY cycles, sticky error.
    run_instr("tmo", 16'h0000, 16'h0080, 16'h0000, 1, 0, 1, 1, 0, 0, 3'd4, 20, 16'hDEAD);
    run_instr("after_tmo", 16'h0000, 16'h7777, 16'h0000, 0, 0, 0, 1, 0, 0, 3'd6, 1, 16'hFFFF);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      k    = int'($urandom_range(0, 5));
      a = 16'($urandom); w = 16'($urandom); p = 16'($urandom); r = 16'($urandom);
      case (kind)
        0: run_instr("rnd_alu", p, a, w, 0, 0, 0, 1'($urandom), 0, 0, 3'($urandom), k, r);
        1: run_instr("rnd_load", p, a, w, 1, 1'($urandom), 1, 1, 0, 0, 3'($urandom), k, r);
        2: run_instr("rnd_store", p, a, w, 0, 1, 0, 1'($urandom), 0, 0, 3'($urandom), k, r);
        default: run_instr("rnd_jmp", p, a, w, 0, 0, 0, 1, 1, 0, 3'($urandom), k, r);
      endcase
    end

    // Reset in the middle of a BUSY access.
    d_ALU_out = 16'h0200; d_mem_read = 1; d_memtoreg = 1; d_regwrite = 1; d_writereg = 3'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rstbusy.stall", {15'd0, stall}, 16'd0);
    check("rstbusy.req", {14'd0, mem_rd_req, mem_wr_req}, 16'd0);
    check_q("rstbusy");
    d_ALU_out = 16'h0; d_mem_read = 0; d_memtoreg = 0; d_regwrite = 0; d_writereg = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    // Late mem_done must not be taken as a load completion.
    run_instr("late_done", 16'h0000, 16'h0055, 16'h0000, 0, 0, 0, 1, 0, 0, 3'd2, 1, 16'hFFFF);

    // jumpl, then halt, then requests are ignored.
    run_instr("jumpl", 16'h0102, 16'h0999, 16'h0000, 0, 0, 0, 1, 1, 0, 3'd7, 0, 16'h0);
    run_instr("halt", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 3'd0, 0, 16'h0);
    run_instr("halted_rd", 16'h0000, 16'h0044, 16'h0000, 1, 0, 1, 1, 0, 0, 3'd1, 0, 16'h0);
    run_instr("halted_wr", 16'h0000, 16'h0045, 16'h0011, 0, 1, 0, 1, 0, 0, 3'd1, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
